// File: rtl/cu_pkg.sv
// -----------------------------------------------------------------------------
// cu_pkg
// Definitions shared by the instruction fetch stage and the control unit:
//   - fmt_e         : instruction format codes carried in if_instr[27:26]
//   - *_MSB/*_LSB   : bit positions of the decoded instruction fields
//   - fetch_state_e : fetch FSM states
//   - RESET_PC      : first fetch address after reset
// -----------------------------------------------------------------------------
package cu_pkg;

    typedef enum logic [1:0] {
        FMT_ALU = 2'b00,
        FMT_LS  = 2'b01,
        FMT_BR  = 2'b10
    } fmt_e;

    localparam int COND_MSB = 31;
    localparam int COND_LSB = 28;
    localparam int FMT_MSB  = 27;
    localparam int FMT_LSB  = 26;
    localparam int CTRL_MSB = 25;
    localparam int CTRL_LSB = 21;
    localparam int SETC_BIT = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// -----------------------------------------------------------------------------
// pc_reg
// Program counter: holds, increments by one word, or loads a redirect target.
// Redirect has priority over increment. Arithmetic wraps modulo 2^32 and the
// two low bits are always zero.
//   clk, rst_n   : clock, asynchronous active-low reset (pc -> RESET_PC)
//   inc_i        : advance pc by 4
//   redirect_i   : load target_i (low two bits cleared)
//   target_i     : redirect address
//   pc_o         : current program counter
// -----------------------------------------------------------------------------
module pc_reg
    import cu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = target_i & 32'hFFFF_FFFC;
        end else if (inc_i) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Single-entry instruction fetch stage. Requests the word at pc from
// instruction memory, holds the returned instruction for the decode stage
// until it is accepted, and handles branch redirects, including a redirect
// that arrives while a request is still outstanding (the late response is
// dropped).
//   clk, rst_n             : clock, asynchronous active-low reset
//   imem_req/imem_addr     : memory read request and word address
//   imem_ack/imem_rdata    : memory response
//   id_ready               : decode accepts the held instruction
//   br_taken/br_target     : redirect request and address
//   if_valid/if_instr/if_pc: held instruction and its address
//   if_condition/if_format/if_controls/if_set_cond : field slices of if_instr
// -----------------------------------------------------------------------------
module instr_fetch
    import cu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_ready,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [3:0]  if_condition,
    output logic [1:0]  if_format,
    output logic [4:0]  if_controls,
    output logic        if_set_cond
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc;
    logic         pc_inc;
    logic         pc_redirect;
    // Address of the request still in flight while in DROP; pc already
    // points at the redirect target by then.
    logic [31:0]  drop_addr_q, drop_addr_d;
    logic [31:0]  if_instr_q, if_instr_d;
    logic [31:0]  if_pc_q, if_pc_d;

    pc_reg u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (pc_inc),
        .redirect_i (pc_redirect),
        .target_i   (br_target),
        .pc_o       (pc)
    );

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        pc_inc      = 1'b0;
        pc_redirect = 1'b0;
        drop_addr_d = drop_addr_q;
        if_instr_d  = if_instr_q;
        if_pc_d     = if_pc_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack && !br_taken) begin
                    if_instr_d = imem_rdata;
                    if_pc_d    = pc;
                    pc_inc     = 1'b1;
                    state_d    = FULL;
                end else if (imem_ack) begin
                    // Response belongs to the wrong path; reissue at target.
                    pc_redirect = 1'b1;
                end else if (br_taken) begin
                    pc_redirect = 1'b1;
                    drop_addr_d = pc;
                    state_d     = DROP;
                end
            end
            DROP: begin
                // Later redirects just replace the target; the old request
                // is still the one on the bus.
                pc_redirect = br_taken;
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            FULL: begin
                if (br_taken) begin
                    pc_redirect = 1'b1;
                    state_d     = FETCH;
                end else if (id_ready) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            drop_addr_q <= RESET_PC;
            if_instr_q  <= 32'h0;
            if_pc_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            drop_addr_q <= drop_addr_d;
            if_instr_q  <= if_instr_d;
            if_pc_q     <= if_pc_d;
        end
    end

    assign imem_req     = (state_q == FETCH) || (state_q == DROP);
    assign imem_addr    = (state_q == DROP) ? drop_addr_q : pc;
    assign if_valid     = (state_q == FULL);
    assign if_instr     = if_instr_q;
    assign if_pc        = if_pc_q;
    assign if_condition = if_instr_q[COND_MSB:COND_LSB];
    assign if_format    = if_instr_q[FMT_MSB:FMT_LSB];
    assign if_controls  = if_instr_q[CTRL_MSB:CTRL_LSB];
    assign if_set_cond  = if_instr_q[SETC_BIT];

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed scenarios followed by randomized traffic, all compared against a
// transaction-level model of the fetch stage (outstanding request, held
// instruction, discard flag).
// -----------------------------------------------------------------------------
module tb_instr_fetch;
    import cu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [3:0]  if_condition;
    logic [1:0]  if_format;
    logic [4:0]  if_controls;
    logic        if_set_cond;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    logic        m_startup;
    logic        m_pending;
    logic        m_discard;
    logic [31:0] m_req_addr;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;

    instr_fetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .id_ready     (id_ready),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_condition (if_condition),
        .if_format    (if_format),
        .if_controls  (if_controls),
        .if_set_cond  (if_set_cond)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_startup  = 1'b1;
        m_pending  = 1'b0;
        m_discard  = 1'b0;
        m_req_addr = 32'h0;
        m_pc       = 32'h0;
        m_valid    = 1'b0;
        m_instr    = 32'h0;
        m_ipc      = 32'h0;
    endtask

    task automatic model_step(input logic ack, input logic [31:0] rd, input logic rdy,
                              input logic br, input logic [31:0] tgt);
        logic [31:0] tgt_w;
        tgt_w = {tgt[31:2], 2'b00};
        if (m_startup) begin
            m_startup  = 1'b0;
            m_pending  = 1'b1;
            m_req_addr = m_pc;
        end else if (m_pending) begin
            if (ack) begin
                if (br || m_discard) begin
                    if (br) m_pc = tgt_w;
                    m_discard  = 1'b0;
                    m_req_addr = m_pc;
                end else begin
                    m_valid   = 1'b1;
                    m_instr   = rd;
                    m_ipc     = m_req_addr;
                    m_pc      = m_pc + 32'd4;
                    m_pending = 1'b0;
                end
            end else if (br) begin
                m_pc      = tgt_w;
                m_discard = 1'b1;
            end
        end else if (m_valid) begin
            if (br || rdy) begin
                if (br) m_pc = tgt_w;
                m_valid    = 1'b0;
                m_pending  = 1'b1;
                m_req_addr = m_pc;
            end
        end
    endtask

    task automatic compare_model();
        check("imem_req", 32'(imem_req), 32'(m_pending));
        if (m_pending) check("imem_addr", imem_addr, m_req_addr);
        check("if_valid", 32'(if_valid), 32'(m_valid));
        if (m_valid) begin
            check("if_instr", if_instr, m_instr);
            check("if_pc", if_pc, m_ipc);
            check("if_condition", 32'(if_condition), 32'(m_instr[31:28]));
            check("if_format", 32'(if_format), 32'(m_instr[27:26]));
            check("if_controls", 32'(if_controls), 32'(m_instr[25:21]));
            check("if_set_cond", 32'(if_set_cond), 32'(m_instr[20]));
        end
    endtask

    // Called just after a falling edge: apply inputs, let one rising edge
    // happen, then compare at the following falling edge.
    task automatic cycle(input logic ack, input logic [31:0] rd, input logic rdy,
                         input logic br, input logic [31:0] tgt);
        imem_ack   = ack;
        imem_rdata = rd;
        id_ready   = rdy;
        br_taken   = br;
        br_target  = tgt;
        @(posedge clk);
        model_step(ack, rd, rdy, br, tgt);
        @(negedge clk);
        compare_model();
    endtask

    // Asserts reset mid-cycle (away from any edge), checks outputs respond
    // without a clock edge, then releases just after the next falling edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'h0);
        check("rst_if_valid", 32'(if_valid), 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);
        model_reset();
        imem_ack = 1'b0;
        br_taken = 1'b0;
        id_ready = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        compare_model();
    endtask

    initial begin
        logic        ack, rdy, br;
        logic [31:0] tgt;

        model_reset();
        @(negedge clk);
        do_reset();

        // Reset release, ack on second FETCH cycle, then stall 5 cycles.
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("first_req_addr", imem_addr, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'hE081_0002, 1'b0, 1'b0, 32'h0);
        check("d34_valid", 32'(if_valid), 32'h1);
        check("d34_pc", if_pc, 32'h0);
        check("d34_cond", 32'(if_condition), 32'hE);
        check("d34_fmt", 32'(if_format), 32'(FMT_ALU));
        check("d34_ctrl", 32'(if_controls), 32'b00100);
        check("d34_setc", 32'(if_set_cond), 32'h0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("d35_instr", if_instr, 32'hE081_0002);
        check("d35_req", 32'(imem_req), 32'h0);
        check("d35_pc", imem_addr, 32'h4);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("d34_next_addr", imem_addr, 32'h4);

        // Redirect with no ack: old request stays on the bus, late data dropped.
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h103);
        check("d36_hold_addr", imem_addr, 32'h4);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
        check("d36_valid", 32'(if_valid), 32'h0);
        check("d36_addr", imem_addr, 32'h100);

        // Redirect coincident with ack.
        cycle(1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h200);
        check("d37_valid", 32'(if_valid), 32'h0);
        check("d37_addr", imem_addr, 32'h200);

        // Wrap from the top of the address space.
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        check("d38_req_addr", imem_addr, 32'hFFFF_FFFC);
        cycle(1'b1, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'h0);
        check("d38_if_pc", if_pc, 32'hFFFF_FFFC);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("d38_wrap_addr", imem_addr, 32'h0);

        // Reset during FETCH at 0x40.
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
        cycle(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
        check("d39_pre_addr", imem_addr, 32'h40);
        do_reset();
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("d39_post_addr", imem_addr, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            ack = m_pending && ($urandom_range(2) == 0);
            rdy = ($urandom_range(1) == 0);
            br  = ($urandom_range(7) == 0);
            tgt = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                           : $urandom;
            cycle(ack, $urandom, rdy, br, tgt);
            if (n == 1500) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
